// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture pipeline: source-mode encodings
// and the alternating test-pattern constant.
package adc_capture_pkg;

   typedef enum logic [1:0] {
      MODE_ADC   = 2'd0,
      MODE_COUNT = 2'd1,
      MODE_ALT   = 2'd2,
      MODE_MID   = 2'd3
   } mode_e;

   localparam int unsigned MAX_WIDTH = 16;

   // phase 0 yields ...0101 (LSB set), phase 1 yields ...1010.
   function automatic logic [MAX_WIDTH-1:0] alt_pattern(input logic phase);
      logic [MAX_WIDTH-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         p[i] = (i[0] == phase);
      end
      return p;
   endfunction

endpackage

// File: rtl/adc_capture_pipe_sample_fifo.sv
// Parametrised synchronous FIFO with registered storage; head is the entry at
// the read pointer. A push into a full FIFO is dropped unless a pop coincides.
module sample_fifo #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clock,
   input  logic                  nReset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty,
   output logic                  drop
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]           wr_q, wr_d;
   logic [AW:0]           rd_q, rd_d;
   logic                  do_pop;
   logic                  do_push;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;
   assign head    = mem_q[rd_q[AW-1:0]];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (do_push) begin
         mem_d[wr_q[AW-1:0]] = din;
         wr_d                = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
      end
   end

endmodule

// File: rtl/adc_capture_pipe.sv
// ADC capture pipeline: falling-edge ADC capture, test-source select, optional
// two's-complement conversion, clip/overflow monitoring and an output FIFO.
module adc_capture_pipe
   import adc_capture_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TEST_STEP  = 1,
   parameter int unsigned CLIP_RUN   = 8
) (
   input  logic                  clock,
   input  logic                  nReset,
   input  logic [DATA_WIDTH-1:0] adcDatabus,
   input  logic [1:0]            mode,
   input  logic                  signedOut,
   input  logic                  enable,
   output logic [DATA_WIDTH-1:0] outData,
   output logic                  outValid,
   input  logic                  outReady,
   output logic                  clipFlag,
   output logic                  overflowFlag,
   input  logic                  statusClear
);

   localparam int unsigned           RW       = $clog2(CLIP_RUN + 1);
   localparam logic [RW-1:0]         RUN_MAX  = RW'(CLIP_RUN);
   localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(TEST_STEP);
   localparam logic [MAX_WIDTH-1:0]  ALT0_FULL = alt_pattern(1'b0);
   localparam logic [MAX_WIDTH-1:0]  ALT1_FULL = alt_pattern(1'b1);
   localparam logic [DATA_WIDTH-1:0] ALT0     = ALT0_FULL[DATA_WIDTH-1:0];
   localparam logic [DATA_WIDTH-1:0] ALT1     = ALT1_FULL[DATA_WIDTH-1:0];

   logic [DATA_WIDTH-1:0] adc_reg_q;
   logic [DATA_WIDTH-1:0] stage_q, stage_d;
   logic                  stage_valid_q, stage_valid_d;
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
   logic                  phase_q, phase_d;
   logic [RW-1:0]         run_q, run_d;
   logic                  clip_q, clip_d;
   logic                  ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0] raw;
   logic [RW-1:0]         run_base;
   logic                  rail;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  fifo_drop;
   mode_e                 mode_sel;

   assign mode_sel = mode_e'(mode);

   always_ff @(negedge clock or negedge nReset) begin
      if (!nReset) adc_reg_q <= '0;
      else         adc_reg_q <= adcDatabus;
   end

   always_comb begin
      raw     = adc_reg_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      case (mode_sel)
         MODE_ADC:   raw = adc_reg_q;
         MODE_COUNT: begin
            raw = cnt_q;
            if (enable) cnt_d = cnt_q + STEP;
         end
         MODE_ALT:   begin
            raw = phase_q ? ALT1 : ALT0;
            if (enable) phase_d = ~phase_q;
         end
         MODE_MID:   raw = MSB_MASK;
         default:    raw = adc_reg_q;
      endcase

      stage_valid_d = enable;
      stage_d       = stage_q;
      if (enable) stage_d = signedOut ? (raw ^ MSB_MASK) : raw;

      // A clear zeroes the run before the current sample is counted, so a
      // rail sample in the clear cycle still starts a new run.
      rail     = (raw == '0) || (raw == '1);
      run_base = statusClear ? '0 : run_q;
      run_d    = run_base;
      if (enable) begin
         if (!rail)                run_d = '0;
         else if (run_base != RUN_MAX) run_d = run_base + 1'b1;
      end

      clip_d = (clip_q && !statusClear) || (run_d == RUN_MAX);
      ovf_d  = (ovf_q && !statusClear) || fifo_drop;
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         stage_q       <= '0;
         stage_valid_q <= 1'b0;
         cnt_q         <= '0;
         phase_q       <= 1'b0;
         run_q         <= '0;
         clip_q        <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         stage_q       <= stage_d;
         stage_valid_q <= stage_valid_d;
         cnt_q         <= cnt_d;
         phase_q       <= phase_d;
         run_q         <= run_d;
         clip_q        <= clip_d;
         ovf_q         <= ovf_d;
      end
   end

   sample_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .nReset (nReset),
      .push   (stage_valid_q),
      .pop    (outValid && outReady),
      .din    (stage_q),
      .head   (outData),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .drop   (fifo_drop)
   );

   assign outValid     = !fifo_empty;
   assign clipFlag     = clip_q;
   assign overflowFlag = ovf_q;

endmodule

// File: tb/tb_adc_capture_pipe.sv
// Directed bench for adc_capture_pipe: a single-sample vector table plus
// hand-written sequences for streaming, overflow, clipping and reset.
module tb_adc_capture_pipe;

   logic       clock;
   logic       nReset;
   logic [9:0] adcDatabus;
   logic [1:0] mode;
   logic       signedOut;
   logic       enable;
   logic [9:0] outData;
   logic       outValid;
   logic       outReady;
   logic       clipFlag;
   logic       overflowFlag;
   logic       statusClear;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   typedef struct {
      logic [1:0] mode;
      logic       sgn;
      logic [9:0] adc;
      logic [9:0] expd;
   } vec_t;

   vec_t vecs [11];

   adc_capture_pipe #(
      .DATA_WIDTH (10),
      .FIFO_DEPTH (4),
      .TEST_STEP  (3),
      .CLIP_RUN   (8)
   ) dut (
      .clock        (clock),
      .nReset       (nReset),
      .adcDatabus   (adcDatabus),
      .mode         (mode),
      .signedOut    (signedOut),
      .enable       (enable),
      .outData      (outData),
      .outValid     (outValid),
      .outReady     (outReady),
      .clipFlag     (clipFlag),
      .overflowFlag (overflowFlag),
      .statusClear  (statusClear)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expd);
      n_checks++;
      if (act !== expd) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expd);
      end
   endtask

   // Pulse reset between edges; returns 3 time units after a rising edge.
   task automatic do_reset();
      @(posedge clock);
      #1;
      nReset = 1'b0;
      #2;
      nReset = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{2'd0, 1'b0, 10'h2A5, 10'h2A5};
      vecs[1]  = '{2'd0, 1'b1, 10'h2A5, 10'h0A5};
      vecs[2]  = '{2'd1, 1'b0, 10'h000, 10'h000};
      vecs[3]  = '{2'd1, 1'b0, 10'h000, 10'h003};
      vecs[4]  = '{2'd2, 1'b0, 10'h000, 10'h155};
      vecs[5]  = '{2'd0, 1'b0, 10'h123, 10'h123};
      vecs[6]  = '{2'd2, 1'b0, 10'h000, 10'h2AA};
      vecs[7]  = '{2'd1, 1'b1, 10'h000, 10'h206};
      vecs[8]  = '{2'd3, 1'b0, 10'h000, 10'h200};
      vecs[9]  = '{2'd3, 1'b1, 10'h000, 10'h000};
      vecs[10] = '{2'd2, 1'b1, 10'h000, 10'h355};

      nReset      = 1'b0;
      adcDatabus  = '0;
      mode        = 2'd0;
      signedOut   = 1'b0;
      enable      = 1'b0;
      outReady    = 1'b0;
      statusClear = 1'b0;
      #2;
      check("rst_valid", 16'(outValid), 16'd0);
      check("rst_data", 16'(outData), 16'd0);
      check("rst_clip", 16'(clipFlag), 16'd0);
      check("rst_ovf", 16'(overflowFlag), 16'd0);
      tick();
      nReset = 1'b1;

      // Single samples: latency, source select, sign conversion, state hold.
      for (int i = 0; i < 11; i++) begin
         mode       = vecs[i].mode;
         signedOut  = vecs[i].sgn;
         adcDatabus = vecs[i].adc;
         enable     = 1'b1;
         outReady   = 1'b0;
         tick();
         enable = 1'b0;
         check($sformatf("vec%0d_lat", i), 16'(outValid), 16'd0);
         tick();
         check($sformatf("vec%0d_valid", i), 16'(outValid), 16'd1);
         check($sformatf("vec%0d_data", i), 16'(outData), 16'(vecs[i].expd));
         outReady = 1'b1;
         tick();
         outReady = 1'b0;
         check($sformatf("vec%0d_empty", i), 16'(outValid), 16'd0);
      end
      signedOut = 1'b0;

      // Counter streaming with wrap.
      do_reset();
      mode     = 2'd1;
      outReady = 1'b1;
      enable   = 1'b1;
      tick();
      for (int i = 0; i < 400; i++) begin
         tick();
         check($sformatf("cnt%0d", i), {5'd0, outValid, outData}, {5'd0, 1'b1, 10'((3 * i) % 1024)});
      end
      enable = 1'b0;
      repeat (3) tick();

      // Alternating pattern, then switch to midscale.
      do_reset();
      mode     = 2'd2;
      outReady = 1'b1;
      enable   = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("alt%0d", i), 16'(outData), (i % 2 == 0) ? 16'h155 : 16'h2AA);
      end
      mode = 2'd3;
      tick();
      tick();
      check("mid_data", 16'(outData), 16'h200);
      enable = 1'b0;
      repeat (3) tick();

      // Overflow with consumer stalled, then drain.
      do_reset();
      mode     = 2'd1;
      outReady = 1'b0;
      enable   = 1'b1;
      repeat (5) tick();
      check("full_no_ovf", 16'(overflowFlag), 16'd0);
      tick();
      enable = 1'b0;
      check("ovf_set", 16'(overflowFlag), 16'd1);
      tick();
      check("ovf_head", {5'd0, outValid, outData}, {5'd0, 1'b1, 10'd0});
      outReady = 1'b1;
      for (int k = 1; k < 4; k++) begin
         tick();
         check($sformatf("drain%0d", k), 16'(outData), 16'(3 * k));
      end
      tick();
      check("drain_empty", 16'(outValid), 16'd0);
      check("ovf_sticky", 16'(overflowFlag), 16'd1);
      statusClear = 1'b1;
      tick();
      statusClear = 1'b0;
      check("ovf_clear", 16'(overflowFlag), 16'd0);

      // Push and pop together while full: nothing dropped.
      outReady = 1'b0;
      enable   = 1'b1;
      repeat (5) tick();
      check("refill_head", {5'd0, outValid, outData}, {5'd0, 1'b1, 10'd18});
      outReady = 1'b1;
      tick();
      enable = 1'b0;
      check("pp_no_ovf", 16'(overflowFlag), 16'd0);
      check("pp_head", 16'(outData), 16'd21);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("pp_drain%0d", k), 16'(outData), 16'(24 + 3 * k));
      end
      tick();
      check("pp_empty", 16'(outValid), 16'd0);
      check("pp_ovf_final", 16'(overflowFlag), 16'd0);

      // Clip detection on a run of rail samples.
      do_reset();
      mode       = 2'd0;
      adcDatabus = 10'h3FF;
      outReady   = 1'b1;
      enable     = 1'b1;
      repeat (7) tick();
      check("clip_7", 16'(clipFlag), 16'd0);
      tick();
      check("clip_8", 16'(clipFlag), 16'd1);
      enable      = 1'b0;
      statusClear = 1'b1;
      tick();
      statusClear = 1'b0;
      check("clip_clear", 16'(clipFlag), 16'd0);
      enable = 1'b1;
      repeat (7) tick();
      adcDatabus = 10'h100;
      tick();
      check("clip_break", 16'(clipFlag), 16'd0);
      tick();
      check("clip_break2", 16'(clipFlag), 16'd0);
      enable = 1'b0;
      repeat (6) tick();

      // Reset with samples buffered.
      do_reset();
      mode     = 2'd1;
      outReady = 1'b0;
      enable   = 1'b1;
      repeat (3) tick();
      enable = 1'b0;
      tick();
      check("pre_rst_valid", 16'(outValid), 16'd1);
      #2;
      nReset = 1'b0;
      #1;
      check("mid_rst_valid", 16'(outValid), 16'd0);
      check("mid_rst_data", 16'(outData), 16'd0);
      check("mid_rst_clip", 16'(clipFlag), 16'd0);
      check("mid_rst_ovf", 16'(overflowFlag), 16'd0);
      nReset   = 1'b1;
      enable   = 1'b1;
      outReady = 1'b1;
      tick();
      check("post_rst_lat", 16'(outValid), 16'd0);
      tick();
      check("post_rst_s0", {5'd0, outValid, outData}, {5'd0, 1'b1, 10'd0});
      tick();
      check("post_rst_s1", 16'(outData), 16'd3);
      enable = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_capture_pipe.md
ADC_CAPTURE_PIPE -- requirements
Module: adc_capture_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, ADC sample width in bits (range 4..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in samples (power of two, at least 2).
REQ-003 SHALL have parameter TEST_STEP, default 1, counter test-mode increment.
REQ-004 SHALL have parameter CLIP_RUN, default 8, consecutive rail samples required to set clipFlag.
REQ-005 SHALL have port clock, input, 1, sample clock; the ADC output is valid on the falling edge.
REQ-006 SHALL have port nReset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port adcDatabus, input, DATA_WIDTH, raw ADC bus in offset binary.
REQ-008 SHALL have port mode, input, 2, source select: 0 ADC, 1 counter, 2 alternating, 3 midscale.
REQ-009 SHALL have port signedOut, input, 1, 1 = emit two's complement, 0 = offset binary.
REQ-010 SHALL have port enable, input, 1, sample generation enable.
REQ-011 SHALL have port outData, output, DATA_WIDTH, FIFO head sample.
REQ-012 SHALL have port outValid, output, 1, FIFO not empty.
REQ-013 SHALL have port outReady, input, 1, consumer accepts head.
REQ-014 SHALL have port clipFlag, output, 1, sticky clip indication.
REQ-015 SHALL have port overflowFlag, output, 1, sticky dropped-sample indication.
REQ-016 SHALL have port statusClear, input, 1, clears clipFlag, overflowFlag and the clip run counter.

Function
REQ-017 SHALL register adcDatabus into adcReg on every falling clock edge, regardless of enable.
REQ-018 SHALL perform all other state updates on the rising clock edge.
REQ-019 SHALL, on each rising edge with enable=1, generate one raw sample into the stage register and set stageValid=1; with enable=0, SHALL clear stageValid.
REQ-020 SHALL take the raw sample per mode:
  - mode 0: adcReg.
  - mode 1: counter value; the counter then adds TEST_STEP modulo 2^DATA_WIDTH (wrap from all-ones+1 to 0).
  - mode 2: alternating 0101..01 and 1010..10, starting with 0101..01 after reset.
  - mode 3: constant 2^(DATA_WIDTH-1).
REQ-021 SHALL advance the counter and pattern phase only when a sample is generated in their own mode, and otherwise hold them.
REQ-022 SHALL have a mode change take effect on the next generated sample, with no flush of buffered data.
REQ-023 SHALL, when signedOut=1, invert the MSB of the raw sample before it enters the FIFO; signedOut SHALL be sampled in the same cycle as the raw sample.
REQ-024 SHALL treat a raw sample equal to 0 or to all-ones as a rail sample.
REQ-025 SHALL increment the run counter on each rail sample, saturating at CLIP_RUN, and reset it to 0 on any non-rail sample.
REQ-026 SHALL set clipFlag when the run counter reaches CLIP_RUN.
REQ-027 SHALL write the stage register into the FIFO on the rising edge after stageValid=1.
REQ-028 SHALL give a latency from falling-edge capture to outValid of two rising edges when the FIFO is empty.
REQ-029 SHALL pop the FIFO head on a rising edge when outValid=1 and outReady=1.
REQ-030 SHALL present outData from the head register, and SHALL hold outData stable while outValid=1 and outReady=0.
REQ-031 SHALL, on a push while the FIFO is full with no simultaneous pop, drop the new sample, leave the stored data unchanged and set overflowFlag.
REQ-032 SHALL, on a push and pop in the same cycle while the FIFO is full, accept the push with no drop and no overflow.
REQ-033 SHALL, on a push and pop in the same cycle while the FIFO is empty, perform the push only, with outValid rising next cycle.
REQ-034 SHALL give a set event priority over statusClear in the same cycle.

Reset
REQ-035 SHALL, on nReset low, asynchronously set adcReg, stage, counter and run count to 0, set the pattern phase to 0101..01, empty the FIFO, and drive outData=0, outValid=0, clipFlag=0, overflowFlag=0.
REQ-036 SHALL, on reset mid-operation, discard all buffered samples, with the first post-reset sample generated on the first rising edge after nReset deasserts.

Structure
REQ-037 SHALL define the mode encodings (MODE_ADC, MODE_COUNT, MODE_ALT, MODE_MID) and the pattern-constant function in shared package adc_capture_pkg.
REQ-038 SHALL implement the FIFO as sub-module sample_fifo, a parametrised synchronous FIFO with push, pop, full, empty and head outputs.

Verification
REQ-039 SHALL cover mode 0 with W=10 and adcDatabus=0x2A5 at a falling edge: outData=0x2A5 with outValid two rising edges later; with signedOut=1, outData=0x0A5.
REQ-040 SHALL cover mode 1 with TEST_STEP=3, outReady=1 and enable=1 for 400 samples: outData sequence 0,3,6,... wrapping 1023 to 2 (mod 1024).
REQ-041 SHALL cover mode 2 with outReady=1: outData alternates 0x155, 0x2AA starting at 0x155; switching to mode 3 yields 0x200.
REQ-042 SHALL cover outReady=0 with 6 samples at FIFO_DEPTH=4: the first 4 are retained, overflowFlag=1, and draining yields samples 1..4; simultaneous push/pop while full drops nothing.
REQ-043 SHALL cover adcDatabus=0x3FF for 8 samples: clipFlag rises after the 8th; 7 rail samples then 0x100 leave clipFlag=0; statusClear clears the flag.
REQ-044 SHALL cover nReset pulsed low with 3 samples buffered: outValid=0 and flags=0 immediately, and the counter restarts at 0.
